// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - upstream/downstream/redirect signal bundle for branch_resolve
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        is_branch;
    logic [2:0]  funct3;
    logic        imm12;
    logic        imm11;
    logic [5:0]  imm10_5;
    logic [3:0]  imm4_1;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_misaligned;
    logic        out_illegal;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        squash;

    modport slave (
        input  in_valid, in_pc, is_branch, funct3, imm12, imm11, imm10_5, imm4_1,
               rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, out_pc, out_taken, out_target, out_misaligned,
               out_illegal, redirect_valid, redirect_pc, squash
    );

    modport master (
        output in_valid, in_pc, is_branch, funct3, imm12, imm11, imm10_5, imm4_1,
               rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, out_pc, out_taken, out_target, out_misaligned,
               out_illegal, redirect_valid, redirect_pc, squash
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - B-type branch evaluation with registered result and fetch redirect/squash
module branch_resolve #(
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_resolve_if.slave bus
);
    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic        out_taken_q;
    logic [31:0] out_target_q;
    logic        out_misaligned_q;
    logic        out_illegal_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        squash_q;

    logic [31:0] imm_ext;
    logic [31:0] br_target;
    logic [31:0] seq_pc;
    logic        cond_true;
    logic        bad_funct3;
    logic        taken;
    logic        illegal;
    logic        misaligned;
    logic [31:0] next_target;
    logic        in_ready;
    logic        accept;
    logic        redirect;

    assign imm_ext   = {{19{bus.imm12}}, bus.imm12, bus.imm11, bus.imm10_5, bus.imm4_1, 1'b0};
    assign br_target = bus.in_pc + imm_ext;
    assign seq_pc    = bus.in_pc + 32'd4;

    always_comb begin
        cond_true  = 1'b0;
        bad_funct3 = 1'b0;
        case (bus.funct3)
            3'b000:  cond_true = (bus.rs1_val == bus.rs2_val);
            3'b001:  cond_true = (bus.rs1_val != bus.rs2_val);
            3'b100:  cond_true = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
            3'b101:  cond_true = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
            3'b110:  cond_true = (bus.rs1_val <  bus.rs2_val);
            3'b111:  cond_true = (bus.rs1_val >= bus.rs2_val);
            default: bad_funct3 = 1'b1;
        endcase
    end

    assign taken       = bus.is_branch && cond_true;
    assign illegal     = bus.is_branch && bad_funct3;
    assign misaligned  = taken && br_target[1];
    assign next_target = taken ? br_target : seq_pc;

    // During squash everything upstream is swallowed, so backpressure is irrelevant.
    assign in_ready = (state_q == SQUASH) ? 1'b1 : (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign redirect = accept && (state_q == RUN) && taken && !br_target[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            cnt_q            <= 4'd0;
            out_valid_q      <= 1'b0;
            out_pc_q         <= 32'd0;
            out_taken_q      <= 1'b0;
            out_target_q     <= 32'd0;
            out_misaligned_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            squash_q         <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (accept) begin
                        out_valid_q      <= 1'b1;
                        out_pc_q         <= bus.in_pc;
                        out_taken_q      <= taken;
                        out_target_q     <= next_target;
                        out_misaligned_q <= misaligned;
                        out_illegal_q    <= illegal;
                        if (redirect) begin
                            state_q          <= SQUASH;
                            cnt_q            <= SQ_LOAD;
                            squash_q         <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= br_target;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                SQUASH: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (cnt_q == 4'd1) begin
                        state_q  <= RUN;
                        squash_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    squash_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_target     = out_target_q;
    assign bus.out_misaligned = out_misaligned_q;
    assign bus.out_illegal    = out_illegal_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.squash         = squash_q;
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution stage that consumes the B-type immediate fields produced by the immediate splitter together with the decoded branch condition and register operands. It reassembles and sign-extends the 13-bit offset, evaluates the condition and computes the target. Results go to a one-entry registered output with valid/ready handshake. A taken, aligned branch raises a one-cycle redirect to fetch and squashes a fixed number of following upstream transfers.

## Interface
- SQUASH_CYCLES, default 2: cycles of upstream squash after a redirect; legal range 1–15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry.
- in_pc  in  32  PC of the instruction.
- is_branch  in  1  instruction is B-type.
- funct3  in  3  branch condition.
- imm12  in  1  offset bit 12.
- imm11  in  1  offset bit 11.
- imm10_5  in  6  offset bits 10:5.
- imm4_1  in  4  offset bits 4:1.
- rs1_val  in  32  operand 1.
- rs2_val  in  32  operand 2.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  downstream accepts the entry.
- out_pc  out  32  registered in_pc.
- out_taken  out  1  branch taken.
- out_target  out  32  next PC: the branch target if taken, else pc+4.
- out_misaligned  out  1  taken target with bit 1 set.
- out_illegal  out  1  is_branch with funct3 010 or 011.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_pc  out  32  redirect address.
- squash  out  1  upstream transfers this cycle are discarded.

## Operation
- Offset: imm = sign-extend({imm12, imm11, imm10_5, imm4_1, 1'b0}) from 13 to 32 bits. Target = in_pc + imm, modulo 2^32; wrap-around is silent.
- funct3 decoding:
  - 000: BEQ.
  - 001: BNE.
  - 100: BLT, signed.
  - 101: BGE, signed.
  - 110: BLTU, unsigned.
  - 111: BGEU, unsigned.
  - 010/011: taken=0, illegal=1.
- Non-branch (is_branch=0): taken=0, illegal=0, misaligned=0, out_target = in_pc+4.
- Not taken: out_target = in_pc+4.
- Misaligned: taken=1 and target[1]=1 → out_misaligned=1, out_target = target, no redirect, no squash.
- Transfer: occurs when in_valid && in_ready.
- in_ready = (!out_valid || out_ready) in state RUN; in_ready = 1 in state SQUASH.
- States:
  - RUN: normal operation. An accepted, taken, aligned branch loads the counter with SQUASH_CYCLES and enters SQUASH.
  - SQUASH: squash=1. Transfers are accepted and dropped; the output register is not loaded. The counter decrements every cycle, and the block returns to RUN when the counter is about to reach 0.
- The output register drains normally during SQUASH: out_valid clears on out_ready.
- redirect_valid is high for exactly the first SQUASH cycle; redirect_pc = the accepted target. Otherwise redirect_valid=0 and redirect_pc holds its last value.
- Reset values: out_valid=0; all data outputs=0; redirect_valid=0; redirect_pc=0; squash=0; state RUN; counter 0.
- Reset mid-SQUASH: squash and redirect_valid drop asynchronously. After release, the block is in RUN with in_ready=1.

## Timing
- Latency: 1 cycle. A transfer at edge N gives out_valid=1 with results after edge N.
- Output hold: out_valid with all out_* fields stays stable while out_ready=0.
- Full throughput: one entry per cycle with out_ready held 1.
- Redirect timing: a redirecting branch accepted at edge N gives redirect_valid and squash high after edge N. squash stays high for SQUASH_CYCLES cycles and falls after edge N+SQUASH_CYCLES.
- Simultaneous events in RUN, same cycle:
  - out_ready=1 with a new transfer → the register reloads with no bubble.
  - out_ready=0 → in_ready=0 and no transfer.
- No new redirect can occur during SQUASH.

## Test plan
- BEQ, in_pc=0x100, imm12=1, imm11=1, imm10_5=0x3F, imm4_1=0xC (−8), rs1=rs2=5.
  - Next cycle: out_taken=1, out_target=0xF8, redirect_valid=1 for 1 cycle, redirect_pc=0xF8.
  - squash=1 for 2 cycles; transfers in those cycles never appear on out_valid.
- Signed/unsigned compare: BLT with rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken, out_target=in_pc+4.
- Misaligned: BEQ taken, in_pc=0x100, imm4_1=0x3 (+6) → out_target=0x106, out_misaligned=1, redirect_valid=0, squash=0.
- Illegal funct3: funct3=010 → out_illegal=1, out_taken=0. Non-branch in_pc=0xFFFFFFFC → out_target=0x0 (wrap).
- Backpressure: out_ready=0 for 3 cycles while holding a result → outputs unchanged, in_ready=0. Raising out_ready with in_valid=1 → back-to-back transfer, no bubble.
- Reset during SQUASH: assert rst_n=0 mid-squash → squash, out_valid and redirect_valid drop immediately. After release → in_ready=1, state RUN.
